uart_receiver: RTL and testbench



---
 rtl/uart_receiver_if.sv | 11 +
 rtl/uart_receiver.sv | 122 ++++++++++++
 tb/tb_uart_receiver.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial line input plus received byte and line-status strobes
interface uart_receiver_if;
  logic RxD;
  logic [7:0] RxD_data;
  logic RxD_data_ready;
  logic RxD_framing_err;
  logic RxD_idle;
  logic RxD_endofpacket;
  modport master (output RxD, input RxD_data, RxD_data_ready, RxD_framing_err, RxD_idle, RxD_endofpacket);
  modport slave (input RxD, output RxD_data, RxD_data_ready, RxD_framing_err, RxD_idle, RxD_endofpacket);
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: oversampled, majority-filtered 8N1 receiver with framing-error, idle and end-of-packet detection
module uart_receiver #(
  parameter int CLK_FREQ = 25000000,
  parameter int BAUD = 115200,
  parameter int OVERSAMPLING = 8,
  parameter int GAP_BITS = 2
) (
  input logic clk,
  input logic rst_n,
  uart_receiver_if.slave bus
);
  localparam int OS_RAW = (CLK_FREQ + BAUD * OVERSAMPLING / 2) / (BAUD * OVERSAMPLING);
  localparam int OS_DIV = OS_RAW < 2 ? 2 : OS_RAW;
  localparam int DIV_W = $clog2(OS_DIV);
  localparam int OS_W = $clog2(OVERSAMPLING);
  localparam int GAP_MAX = GAP_BITS * OVERSAMPLING;
  localparam int GAP_W = $clog2(GAP_MAX + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  logic [DIV_W-1:0] divCnt;
  logic tick;
  logic [1:0] rxSync;
  logic [2:0] hist;
  logic filtered;
  state_t state;
  logic [OS_W-1:0] osCnt;
  logic [2:0] bitCnt;
  logic [7:0] shiftReg;
  logic [GAP_W-1:0] gapCnt;
  logic byteSeen;

  assign tick = divCnt == DIV_W'(OS_DIV - 1);
  assign filtered = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
  assign bus.RxD_idle = gapCnt == GAP_W'(GAP_MAX);

  // free-running oversample tick divider, independent of receive state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) divCnt <= '0;
    else divCnt <= tick ? '0 : divCnt + 1'b1;

  // two-flop synchronizer, then a 3-sample history shifted on each tick for majority voting
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rxSync <= 2'b11;
      hist <= 3'b111;
    end else begin
      rxSync <= {rxSync[0], bus.RxD};
      if (tick) hist <= {hist[1:0], rxSync[1]};
    end

  // frame FSM: start validation at half bit, then one sample per bit period, stop check
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      osCnt <= '0;
      bitCnt <= '0;
      shiftReg <= '0;
      bus.RxD_data <= '0;
      bus.RxD_data_ready <= 1'b0;
      bus.RxD_framing_err <= 1'b0;
    end else begin
      bus.RxD_data_ready <= 1'b0;
      bus.RxD_framing_err <= 1'b0;
      if (tick)
        case (state)
          IDLE:
            if (!filtered) begin
              state <= START;
              osCnt <= '0;
            end
          START:
            if (osCnt == OS_W'(OVERSAMPLING / 2 - 1)) begin
              state <= filtered ? IDLE : DATA;
              osCnt <= '0;
              bitCnt <= '0;
            end else osCnt <= osCnt + 1'b1;
          DATA: begin
            osCnt <= osCnt + 1'b1;
            if (osCnt == OS_W'(OVERSAMPLING - 1)) begin
              shiftReg <= {filtered, shiftReg[7:1]};
              bitCnt <= bitCnt + 1'b1;
              if (bitCnt == 3'd7) state <= STOP;
            end
          end
          STOP: begin
            osCnt <= osCnt + 1'b1;
            if (osCnt == OS_W'(OVERSAMPLING - 1)) begin
              if (filtered) begin
                bus.RxD_data <= shiftReg;
                bus.RxD_data_ready <= 1'b1;
                state <= IDLE;
              end else begin
                bus.RxD_framing_err <= 1'b1;
                state <= BREAK;
              end
            end
          end
          BREAK: if (filtered) state <= IDLE;
          default: state <= IDLE;
        endcase
    end

  // idle gap counter and one end-of-packet pulse when idle begins after received data
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gapCnt <= '0;
      byteSeen <= 1'b0;
      bus.RxD_endofpacket <= 1'b0;
    end else begin
      bus.RxD_endofpacket <= 1'b0;
      if (bus.RxD_data_ready) byteSeen <= 1'b1;
      if (state != IDLE || !filtered) gapCnt <= '0;
      else if (tick && !bus.RxD_idle) begin
        gapCnt <= gapCnt + 1'b1;
        if (gapCnt == GAP_W'(GAP_MAX - 1) && byteSeen) begin
          bus.RxD_endofpacket <= 1'b1;
          byteSeen <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed and random 8N1 frames checked against expected bytes, strobes and idle timing
module tb_uart_receiver;
  localparam int BIT = 160;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int passed = 0;
  int errCnt = 0;
  int eopCnt = 0;
  int rdyCyc = 0;
  int eopCyc = -1;
  int idleCyc = -1;
  int startCyc = 0;
  int lat, e0, p0;
  logic [7:0] errData = '0;
  logic idleSeen = 1'b0;
  logic idleBetween = 1'b0;
  logic badStrobe = 1'b0;
  logic pRdy = 1'b0, pErr = 1'b0, pEop = 1'b0, pIdle = 1'b0;
  logic [7:0] rxQ[$];
  logic [7:0] rnd[6];

  uart_receiver_if bus();

  uart_receiver #(.CLK_FREQ(1600000), .BAUD(100000), .OVERSAMPLING(8), .GAP_BITS(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.RxD_data_ready) begin
      rxQ.push_back(bus.RxD_data);
      rdyCyc = cyc;
      idleBetween = idleSeen;
      idleSeen = 1'b0;
    end else if (bus.RxD_idle) idleSeen = 1'b1;
    if (bus.RxD_framing_err) begin
      errCnt++;
      errData = bus.RxD_data;
    end
    if (bus.RxD_endofpacket) begin
      eopCnt++;
      eopCyc = cyc;
    end
    if (bus.RxD_idle && !pIdle) idleCyc = cyc;
    if ((bus.RxD_data_ready && bus.RxD_framing_err) || (bus.RxD_data_ready && pRdy) ||
        (bus.RxD_framing_err && pErr) || (bus.RxD_endofpacket && pEop)) badStrobe = 1'b1;
    pRdy = bus.RxD_data_ready;
    pErr = bus.RxD_framing_err;
    pEop = bus.RxD_endofpacket;
    pIdle = bus.RxD_idle;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [8:0] popByte();
    return rxQ.size() > 0 ? {1'b0, rxQ.pop_front()} : 9'h1ff;
  endfunction

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic stopBit, input int bitNs);
    startCyc = cyc;
    bus.RxD = 1'b0;
    #(bitNs);
    for (int i = 0; i < 8; i++) begin
      bus.RxD = b[i];
      #(bitNs);
    end
    bus.RxD = stopBit;
    #(bitNs);
  endtask

  initial begin
    bus.RxD = 1'b1;
    waitClk(3);
    check("reset_data", {24'd0, bus.RxD_data}, 32'h00);
    check("reset_ready", {31'd0, bus.RxD_data_ready}, 32'd0);
    check("reset_ferr", {31'd0, bus.RxD_framing_err}, 32'd0);
    check("reset_idle", {31'd0, bus.RxD_idle}, 32'd0);
    check("reset_eop", {31'd0, bus.RxD_endofpacket}, 32'd0);
    rst_n = 1'b1;
    waitClk(40);
    check("postreset_idle", {31'd0, bus.RxD_idle}, 32'd1);
    check("postreset_no_eop", eopCnt, 0);

    align();
    sendFrame(8'hA5, 1'b1, BIT);
    waitClk(10);
    check("t1_count", rxQ.size(), 1);
    lat = rdyCyc - startCyc;
    check("t1_data", popByte(), 32'hA5);
    check("t1_latency_145_160", {31'd0, lat >= 145 && lat <= 160}, 32'd1);
    check("t1_no_ferr", errCnt, 0);

    align();
    sendFrame(8'h00, 1'b1, BIT);
    sendFrame(8'hFF, 1'b1, BIT);
    waitClk(10);
    check("t2_count", rxQ.size(), 2);
    check("t2_first", popByte(), 32'h00);
    check("t2_second", popByte(), 32'hFF);
    check("t2_no_idle_between", {31'd0, idleBetween}, 32'd0);

    align();
    bus.RxD = 1'b0;
    waitClk(2);
    bus.RxD = 1'b1;
    waitClk(16);
    check("t3_glitch_no_data", rxQ.size(), 0);
    check("t3_glitch_no_ferr", errCnt, 0);
    sendFrame(8'h69, 1'b1, BIT);
    waitClk(10);
    check("t3_followup", popByte(), 32'h69);

    e0 = errCnt;
    sendFrame(8'h3C, 1'b0, BIT);
    #(3 * BIT);
    bus.RxD = 1'b1;
    #(2 * BIT);
    check("t4_no_data_on_break", rxQ.size(), 0);
    sendFrame(8'h81, 1'b1, BIT);
    waitClk(10);
    check("t4_one_ferr", errCnt - e0, 1);
    check("t4_data_held", {24'd0, errData}, 32'h69);
    check("t4_count", rxQ.size(), 1);
    check("t4_data", popByte(), 32'h81);

    p0 = eopCnt;
    sendFrame(8'h5A, 1'b1, BIT);
    waitClk(60);
    check("t5_data", popByte(), 32'h5A);
    check("t5_one_eop", eopCnt - p0, 1);
    check("t5_eop_with_idle_rise", eopCyc, idleCyc);
    check("t5_idle_delay", idleCyc - rdyCyc, 32);
    waitClk(100);
    check("t5_no_more_eop", eopCnt - p0, 1);

    align();
    e0 = errCnt;
    bus.RxD = 1'b0;
    #(BIT);
    for (int i = 0; i < 5; i++) begin
      bus.RxD = (8'h96 >> i) & 8'h01 ? 1'b1 : 1'b0;
      #(i == 4 ? BIT / 2 : BIT);
    end
    rst_n = 1'b0;
    #2;
    check("t6_async_reset", {19'd0, bus.RxD_data, bus.RxD_data_ready, bus.RxD_framing_err,
          bus.RxD_idle, bus.RxD_endofpacket}, 32'd0);
    waitClk(3);
    rst_n = 1'b1;
    bus.RxD = 1'b1;
    #(3 * BIT);
    check("t6_partial_discarded", rxQ.size(), 0);
    sendFrame(8'hC3, 1'b1, 165);
    waitClk(20);
    check("t6_slow_count", rxQ.size(), 1);
    check("t6_slow_data", popByte(), 32'hC3);
    check("t6_no_ferr", errCnt - e0, 0);

    align();
    for (int i = 0; i < 6; i++) begin
      rnd[i] = 8'($urandom_range(0, 255));
      sendFrame(rnd[i], 1'b1, BIT);
      #($urandom_range(0, 2) * BIT);
    end
    waitClk(20);
    check("rand_count", rxQ.size(), 6);
    for (int i = 0; i < 6; i++) check($sformatf("rand_%0d", i), popByte(), {24'd0, rnd[i]});
    check("strobes_clean", {31'd0, badStrobe}, 32'd0);
    check("total_ferr", errCnt, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
